// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the Rs5/Rs10 sensors, then emits one
// single-cycle coin code per accepted coin, followed by an idle gap. Rejected coins pulse reject.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin5_in,
    input  logic       coin10_in,
    input  logic       enable,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy,
    output logic [7:0] coin_count
);

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    typedef enum logic {IDLE, EMIT_GAP} state_t;

    state_t     state, state_nx;
    logic [1:0] raw;
    logic [1:0] sync1, sync2, filt, filt_q;
    logic [1:0] ev;
    logic [7:0] gap_cnt;
    logic [1:0] coin_nx;
    logic       reject_nx;
    logic       accept;

    // Bit 0 is the Rs5 line, bit 1 the Rs10 line, so a lone event is already its coin code.
    assign raw = {coin10_in, coin5_in};
    assign ev  = filt & ~filt_q;

    for (genvar g = 0; g < 2; g++) begin : g_line
        logic [7:0] db_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1[g]  <= 1'b0;
                sync2[g]  <= 1'b0;
                filt[g]   <= 1'b0;
                filt_q[g] <= 1'b0;
                db_cnt    <= '0;
            end else begin
                sync1[g]  <= raw[g];
                sync2[g]  <= sync1[g];
                filt_q[g] <= filt[g];
                if (sync2[g] == filt[g]) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    filt[g] <= sync2[g];
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (enable && (ev == 2'b01 || ev == 2'b10)) state_nx = EMIT_GAP;
            EMIT_GAP: if (gap_cnt <= 8'd1) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        coin_nx   = '0;
        reject_nx = 1'b0;
        accept    = 1'b0;
        busy      = (state == EMIT_GAP);
        case (state)
            IDLE: begin
                if (ev != 2'b00) begin
                    if (enable && ev != 2'b11) begin
                        accept  = 1'b1;
                        coin_nx = ev;
                    end else begin
                        reject_nx = 1'b1;
                    end
                end
            end
            EMIT_GAP: reject_nx = (ev != 2'b00);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coin       <= '0;
            reject     <= 1'b0;
            coin_count <= '0;
            gap_cnt    <= '0;
        end else begin
            coin   <= coin_nx;
            reject <= reject_nx;
            if (accept) begin
                gap_cnt <= GAP_LOAD;
                if (coin_count != 8'hFF) coin_count <= coin_count + 8'd1;
            end else if (state == EMIT_GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

endmodule
